// File: rtl/branch_flag_unit.sv
// N/Z/C flag owner for accumulators A and B, with an in-flight scoreboard that stalls branches on unwritten flags.
// Optional define BRANCH_FLAG_FORWARD_EN: bypass writeback flags to the outputs and release the stall in the writeback cycle.
module branch_flag_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iIssueValid,
  input  logic                  iIssueSetsFlagsA,
  input  logic                  iIssueSetsFlagsB,
  input  logic                  iIssueReadsA,
  input  logic                  iIssueReadsB,
  input  logic                  iWbValid,
  input  logic                  iWbSelB,
  input  logic [DATA_WIDTH-1:0] iWbResult,
  input  logic                  iWbCarry,
  output logic                  oN_A,
  output logic                  oZ_A,
  output logic                  oC_A,
  output logic                  oN_B,
  output logic                  oZ_B,
  output logic                  oC_B,
  output logic                  oStall,
  output logic                  oScoreErr
);

  localparam int CW = $clog2(PIPE_DEPTH + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(PIPE_DEPTH);
  localparam logic [CW-1:0] PEND_ONE = CW'(1);

  // flag vectors are {N, Z, C}
  logic [2:0]    flags_a_q, flags_a_d;
  logic [2:0]    flags_b_q, flags_b_d;
  logic [CW-1:0] pend_a_q, pend_a_d;
  logic [CW-1:0] pend_b_q, pend_b_d;
  logic          score_err_q, score_err_d;

  logic [2:0] wb_flags;
  logic       wb_a, wb_b;
  logic       stall_a, stall_b, stall;
  logic       accept;
  logic [CW:0] pend_a_nxt, pend_b_nxt;

  // Returns {error, next count}; simultaneous inc and dec cancel with no error.
  function automatic logic [CW:0] pend_next(input logic [CW-1:0] pend,
                                            input logic inc, input logic dec);
    logic [CW:0] r;
    r = {1'b0, pend};
    if (inc && !dec) begin
      if (pend == PEND_MAX) r[CW] = 1'b1;
      else                  r[CW-1:0] = pend + PEND_ONE;
    end else if (dec && !inc) begin
      if (pend == '0) r[CW] = 1'b1;
      else            r[CW-1:0] = pend - PEND_ONE;
    end
    return r;
  endfunction

  always_comb begin
    wb_flags = {iWbResult[DATA_WIDTH-1], (iWbResult == '0), iWbCarry};
    wb_a     = iWbValid & ~iWbSelB;
    wb_b     = iWbValid & iWbSelB;

    stall_a = iIssueReadsA & (pend_a_q != '0);
    stall_b = iIssueReadsB & (pend_b_q != '0);
`ifdef BRANCH_FLAG_FORWARD_EN
    // last pending result arrives this cycle and is bypassed to the evaluator
    if (wb_a && pend_a_q == PEND_ONE) stall_a = 1'b0;
    if (wb_b && pend_b_q == PEND_ONE) stall_b = 1'b0;
`endif
    stall  = ~Reset & iIssueValid & (stall_a | stall_b);
    accept = iIssueValid & ~stall;

    pend_a_nxt = pend_next(pend_a_q, accept & iIssueSetsFlagsA, wb_a);
    pend_b_nxt = pend_next(pend_b_q, accept & iIssueSetsFlagsB, wb_b);

    pend_a_d    = pend_a_nxt[CW-1:0];
    pend_b_d    = pend_b_nxt[CW-1:0];
    score_err_d = score_err_q | pend_a_nxt[CW] | pend_b_nxt[CW];
    flags_a_d   = wb_a ? wb_flags : flags_a_q;
    flags_b_d   = wb_b ? wb_flags : flags_b_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      flags_a_q   <= '0;
      flags_b_q   <= '0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      score_err_q <= 1'b0;
    end else begin
      flags_a_q   <= flags_a_d;
      flags_b_q   <= flags_b_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      score_err_q <= score_err_d;
    end
  end

  always_comb begin
`ifdef BRANCH_FLAG_FORWARD_EN
    {oN_A, oZ_A, oC_A} = wb_a ? wb_flags : flags_a_q;
    {oN_B, oZ_B, oC_B} = wb_b ? wb_flags : flags_b_q;
`else
    {oN_A, oZ_A, oC_A} = flags_a_q;
    {oN_B, oZ_B, oC_B} = flags_b_q;
`endif
    oStall    = stall;
    oScoreErr = score_err_q;
  end

endmodule
